ls_exec_unit: RTL and testbench

- Load/store execution stage directly downstream of the load/store buffer.
- Accepts one memory op at a time, turns it into a request to the memory controller and holds the request until the controller returns done.
- For loads, extends the returned data to 32 bits by sign or zero and broadcasts it on the LS CDB.
- Stores finish silently, because they are already committed before issue.

---
 rtl/ls_exec_unit.sv | 134 +++++++++++++
 tb/tb_ls_exec_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ls_exec_unit.sv
// Load/store execution stage: turns one issued memory op into a held memory-controller
// request and broadcasts extended load data on the LS CDB when the controller finishes.
module ls_exec_unit #(
   parameter int DATA_LEN   = 32,
   parameter int OPENUM_LEN = 6,
   parameter int ROB_LEN    = 4,
   parameter int OP_LB      = 1,
   parameter int OP_LH      = 2,
   parameter int OP_LW      = 3,
   parameter int OP_LBU     = 4,
   parameter int OP_LHU     = 5,
   parameter int OP_SB      = 6,
   parameter int OP_SH      = 7,
   parameter int OP_SW      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ena_from_lsb,
   input  logic [OPENUM_LEN-1:0] openum_from_lsb,
   input  logic [DATA_LEN-1:0]   mem_addr_from_lsb,
   input  logic [DATA_LEN-1:0]   store_value_from_lsb,
   input  logic [ROB_LEN:0]      rob_id_from_lsb,
   output logic                  busy_to_lsb,
   output logic                  ena_to_mc,
   output logic                  wr_to_mc,
   output logic [DATA_LEN-1:0]   addr_to_mc,
   output logic [DATA_LEN-1:0]   data_to_mc,
   output logic [2:0]            size_to_mc,
   input  logic                  done_from_mc,
   input  logic [DATA_LEN-1:0]   data_from_mc,
   output logic                  valid_to_cdb,
   output logic [ROB_LEN:0]      rob_id_to_cdb,
   output logic [DATA_LEN-1:0]   result_to_cdb,
   input  logic                  commit_jump_flag_from_rob
);

   localparam logic [OPENUM_LEN-1:0] L_LB  = OPENUM_LEN'(OP_LB);
   localparam logic [OPENUM_LEN-1:0] L_LH  = OPENUM_LEN'(OP_LH);
   localparam logic [OPENUM_LEN-1:0] L_LW  = OPENUM_LEN'(OP_LW);
   localparam logic [OPENUM_LEN-1:0] L_LBU = OPENUM_LEN'(OP_LBU);
   localparam logic [OPENUM_LEN-1:0] L_LHU = OPENUM_LEN'(OP_LHU);
   localparam logic [OPENUM_LEN-1:0] L_SB  = OPENUM_LEN'(OP_SB);
   localparam logic [OPENUM_LEN-1:0] L_SH  = OPENUM_LEN'(OP_SH);

   typedef enum logic {IDLE, WAIT_MEM} state_t;

   state_t                r_state;
   logic [OPENUM_LEN-1:0] r_openum;
   logic [ROB_LEN:0]      r_rob_id;
   logic                  r_discard;

   logic                  w_issue_is_load;
   logic                  w_cur_is_load;
   logic [2:0]            w_issue_size;
   logic [DATA_LEN-1:0]   w_load_result;

   // Combinational so the buffer sees busy in the very cycle it strobes an issue.
   assign busy_to_lsb     = (r_state != IDLE) | ena_from_lsb;
   assign w_issue_is_load = (openum_from_lsb <= L_LHU);
   assign w_cur_is_load   = (r_openum <= L_LHU);

   always_comb begin
      w_issue_size = 3'd4;
      if (openum_from_lsb == L_LB || openum_from_lsb == L_LBU || openum_from_lsb == L_SB)
         w_issue_size = 3'd1;
      else if (openum_from_lsb == L_LH || openum_from_lsb == L_LHU || openum_from_lsb == L_SH)
         w_issue_size = 3'd2;
   end

   always_comb begin
      w_load_result = data_from_mc;
      if (r_openum == L_LB)
         w_load_result = {{(DATA_LEN-8){data_from_mc[7]}}, data_from_mc[7:0]};
      else if (r_openum == L_LH)
         w_load_result = {{(DATA_LEN-16){data_from_mc[15]}}, data_from_mc[15:0]};
      else if (r_openum == L_LBU)
         w_load_result = {{(DATA_LEN-8){1'b0}}, data_from_mc[7:0]};
      else if (r_openum == L_LHU)
         w_load_result = {{(DATA_LEN-16){1'b0}}, data_from_mc[15:0]};
      else if (r_openum == L_LW)
         w_load_result = data_from_mc;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= IDLE;
         r_openum      <= '0;
         r_rob_id      <= '0;
         r_discard     <= 1'b0;
         ena_to_mc     <= 1'b0;
         wr_to_mc      <= 1'b0;
         addr_to_mc    <= '0;
         data_to_mc    <= '0;
         size_to_mc    <= 3'd0;
         valid_to_cdb  <= 1'b0;
         rob_id_to_cdb <= '0;
         result_to_cdb <= '0;
      end else begin
         valid_to_cdb <= 1'b0;
         case (r_state)
            IDLE: begin
               if (ena_from_lsb && !commit_jump_flag_from_rob) begin
                  r_openum   <= openum_from_lsb;
                  r_rob_id   <= rob_id_from_lsb;
                  r_discard  <= 1'b0;
                  ena_to_mc  <= 1'b1;
                  wr_to_mc   <= ~w_issue_is_load;
                  addr_to_mc <= mem_addr_from_lsb;
                  data_to_mc <= store_value_from_lsb;
                  size_to_mc <= w_issue_size;
                  r_state    <= WAIT_MEM;
               end
            end
            WAIT_MEM: begin
               // The controller cannot abort, so a flushed load runs to done and is dropped.
               if (commit_jump_flag_from_rob && w_cur_is_load)
                  r_discard <= 1'b1;
               if (done_from_mc) begin
                  ena_to_mc <= 1'b0;
                  r_discard <= 1'b0;
                  r_state   <= IDLE;
                  if (w_cur_is_load && !r_discard && !commit_jump_flag_from_rob) begin
                     valid_to_cdb  <= 1'b1;
                     rob_id_to_cdb <= r_rob_id;
                     result_to_cdb <= w_load_result;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ls_exec_unit.sv
// Directed bench for ls_exec_unit: issue/complete loads and stores, flushes and async reset.
module tb_ls_exec_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        ena_from_lsb;
   logic [5:0]  openum_from_lsb;
   logic [31:0] mem_addr_from_lsb;
   logic [31:0] store_value_from_lsb;
   logic [4:0]  rob_id_from_lsb;
   logic        busy_to_lsb;
   logic        ena_to_mc;
   logic        wr_to_mc;
   logic [31:0] addr_to_mc;
   logic [31:0] data_to_mc;
   logic [2:0]  size_to_mc;
   logic        done_from_mc;
   logic [31:0] data_from_mc;
   logic        valid_to_cdb;
   logic [4:0]  rob_id_to_cdb;
   logic [31:0] result_to_cdb;
   logic        commit_jump_flag_from_rob;

   int checks   = 0;
   int failures = 0;
   int req_count = 0;
   logic prev_ena = 1'b0;

   ls_exec_unit dut (
      .clk                       (clk),
      .rst                       (rst),
      .ena_from_lsb              (ena_from_lsb),
      .openum_from_lsb           (openum_from_lsb),
      .mem_addr_from_lsb         (mem_addr_from_lsb),
      .store_value_from_lsb      (store_value_from_lsb),
      .rob_id_from_lsb           (rob_id_from_lsb),
      .busy_to_lsb               (busy_to_lsb),
      .ena_to_mc                 (ena_to_mc),
      .wr_to_mc                  (wr_to_mc),
      .addr_to_mc                (addr_to_mc),
      .data_to_mc                (data_to_mc),
      .size_to_mc                (size_to_mc),
      .done_from_mc              (done_from_mc),
      .data_from_mc              (data_from_mc),
      .valid_to_cdb              (valid_to_cdb),
      .rob_id_to_cdb             (rob_id_to_cdb),
      .result_to_cdb             (result_to_cdb),
      .commit_jump_flag_from_rob (commit_jump_flag_from_rob)
   );

   always #5 clk = ~clk;

   // Counts memory requests as rising edges of ena_to_mc, sampled just after each clock edge.
   always @(posedge clk) begin
      #1;
      if (ena_to_mc && !prev_ena) req_count++;
      prev_ena = ena_to_mc;
   end

   task automatic do_issue(input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] val, input logic [4:0] rob);
      openum_from_lsb      = op;
      mem_addr_from_lsb    = addr;
      store_value_from_lsb = val;
      rob_id_from_lsb      = rob;
      ena_from_lsb         = 1'b1;
      @(negedge clk);
      ena_from_lsb = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      #1;
      checks++; if (ena_to_mc !== 1'b0) begin failures++; $display("FAIL reset_ena got=%0b exp=0", ena_to_mc); end
      checks++; if (valid_to_cdb !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", valid_to_cdb); end
      checks++; if ({wr_to_mc, size_to_mc, addr_to_mc, data_to_mc} !== 68'd0) begin failures++; $display("FAIL reset_mc got wr=%0b size=%0d addr=%h data=%h exp=0", wr_to_mc, size_to_mc, addr_to_mc, data_to_mc); end
      checks++; if ({rob_id_to_cdb, result_to_cdb} !== 37'd0) begin failures++; $display("FAIL reset_cdb got rob=%0d res=%h exp=0", rob_id_to_cdb, result_to_cdb); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (busy_to_lsb !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy_to_lsb); end
      $display("txn reset done");
   endtask

   task automatic test_lw;
      int n0;
      n0 = req_count;
      do_issue(6'd3, 32'h100, 32'h0, 5'd3);
      for (int i = 0; i < 5; i++) begin
         checks++; if ({ena_to_mc, wr_to_mc, size_to_mc} !== {1'b1, 1'b0, 3'd4}) begin failures++; $display("FAIL lw_req cyc=%0d got ena=%0b wr=%0b size=%0d exp 1/0/4", i, ena_to_mc, wr_to_mc, size_to_mc); end
         checks++; if (valid_to_cdb !== 1'b0) begin failures++; $display("FAIL lw_early_valid cyc=%0d got=%0b exp=0", i, valid_to_cdb); end
         if (i == 4) begin done_from_mc = 1'b1; data_from_mc = 32'h12345678; end
         @(negedge clk);
      end
      done_from_mc = 1'b0;
      checks++; if ({valid_to_cdb, rob_id_to_cdb, result_to_cdb} !== {1'b1, 5'd3, 32'h12345678}) begin failures++; $display("FAIL lw_cdb got v=%0b rob=%0d res=%h exp 1/3/12345678", valid_to_cdb, rob_id_to_cdb, result_to_cdb); end
      checks++; if ({ena_to_mc, busy_to_lsb} !== 2'b00) begin failures++; $display("FAIL lw_after_done got ena=%0b busy=%0b exp 0/0", ena_to_mc, busy_to_lsb); end
      checks++; if (addr_to_mc !== 32'h100) begin failures++; $display("FAIL lw_addr got=%h exp=100", addr_to_mc); end
      @(negedge clk);
      checks++; if (valid_to_cdb !== 1'b0) begin failures++; $display("FAIL lw_pulse_width got=%0b exp=0", valid_to_cdb); end
      checks++; if (req_count - n0 !== 1) begin failures++; $display("FAIL lw_req_count got=%0d exp=1", req_count - n0); end
      $display("txn LW rob=3 result=%h", 32'h12345678);
   endtask

   task automatic test_extend;
      logic [5:0]  ops  [5] = '{6'd1, 6'd4, 6'd2, 6'd5, 6'd1};
      logic [31:0] din  [5] = '{32'h000000F0, 32'h000000F0, 32'h00008001, 32'hFFFF8001, 32'h1234567F};
      logic [31:0] dexp [5] = '{32'hFFFFFFF0, 32'h000000F0, 32'hFFFF8001, 32'h00008001, 32'h0000007F};
      logic [2:0]  sexp [5] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd1};
      for (int k = 0; k < 5; k++) begin
         do_issue(ops[k], 32'h7, 32'h0, 5'(k + 8));
         checks++; if ({size_to_mc, addr_to_mc} !== {sexp[k], 32'h7}) begin failures++; $display("FAIL ext_req k=%0d got size=%0d addr=%h exp %0d/7", k, size_to_mc, addr_to_mc, sexp[k]); end
         done_from_mc = 1'b1; data_from_mc = din[k];
         @(negedge clk);
         done_from_mc = 1'b0; data_from_mc = 32'hFFFFFFFF;
         checks++; if ({valid_to_cdb, rob_id_to_cdb, result_to_cdb} !== {1'b1, 5'(k + 8), dexp[k]}) begin failures++; $display("FAIL ext_result k=%0d got v=%0b rob=%0d res=%h exp 1/%0d/%h", k, valid_to_cdb, rob_id_to_cdb, result_to_cdb, k + 8, dexp[k]); end
         $display("txn op=%0d data=%h result=%h", ops[k], din[k], result_to_cdb);
         @(negedge clk);
      end
   endtask

   task automatic test_store;
      do_issue(6'd7, 32'h20, 32'hAABBCCDD, 5'd4);
      checks++; if ({ena_to_mc, wr_to_mc, size_to_mc, addr_to_mc, data_to_mc} !== {1'b1, 1'b1, 3'd2, 32'h20, 32'hAABBCCDD}) begin failures++; $display("FAIL sh_req got ena=%0b wr=%0b size=%0d addr=%h data=%h", ena_to_mc, wr_to_mc, size_to_mc, addr_to_mc, data_to_mc); end
      checks++; if (busy_to_lsb !== 1'b1) begin failures++; $display("FAIL sh_busy got=%0b exp=1", busy_to_lsb); end
      done_from_mc = 1'b1; data_from_mc = 32'h55555555;
      @(negedge clk);
      done_from_mc = 1'b0;
      checks++; if ({valid_to_cdb, ena_to_mc, busy_to_lsb} !== 3'b000) begin failures++; $display("FAIL sh_done got v=%0b ena=%0b busy=%0b exp 0/0/0", valid_to_cdb, ena_to_mc, busy_to_lsb); end
      @(negedge clk);
      checks++; if (valid_to_cdb !== 1'b0) begin failures++; $display("FAIL sh_no_pulse got=%0b exp=0", valid_to_cdb); end
      $display("txn SH addr=20 data=aabbccdd");
   endtask

   task automatic test_back_to_back;
      int n0;
      n0 = req_count;
      openum_from_lsb = 6'd3; mem_addr_from_lsb = 32'h140; rob_id_from_lsb = 5'd1; ena_from_lsb = 1'b1;
      #1;
      checks++; if (busy_to_lsb !== 1'b1) begin failures++; $display("FAIL b2b_busy_issue got=%0b exp=1", busy_to_lsb); end
      @(negedge clk);
      mem_addr_from_lsb = 32'h200; rob_id_from_lsb = 5'd2;
      @(negedge clk);
      ena_from_lsb = 1'b0;
      checks++; if (addr_to_mc !== 32'h140) begin failures++; $display("FAIL b2b_addr got=%h exp=140", addr_to_mc); end
      done_from_mc = 1'b1; data_from_mc = 32'hCAFE0001;
      @(negedge clk);
      done_from_mc = 1'b0;
      checks++; if ({valid_to_cdb, rob_id_to_cdb} !== {1'b1, 5'd1}) begin failures++; $display("FAIL b2b_cdb got v=%0b rob=%0d exp 1/1", valid_to_cdb, rob_id_to_cdb); end
      @(negedge clk);
      checks++; if ({ena_to_mc, req_count - n0} !== {1'b0, 32'd1}) begin failures++; $display("FAIL b2b_one_req got ena=%0b reqs=%0d exp 0/1", ena_to_mc, req_count - n0); end
      $display("txn back-to-back strobes reqs=%0d", req_count - n0);
   endtask

   task automatic test_flush;
      ena_from_lsb = 1'b1; openum_from_lsb = 6'd3; commit_jump_flag_from_rob = 1'b1;
      @(negedge clk);
      ena_from_lsb = 1'b0; commit_jump_flag_from_rob = 1'b0;
      checks++; if (ena_to_mc !== 1'b0) begin failures++; $display("FAIL flush_idle_issue got=%0b exp=0", ena_to_mc); end
      do_issue(6'd3, 32'h300, 32'h0, 5'd5);
      commit_jump_flag_from_rob = 1'b1;
      @(negedge clk);
      commit_jump_flag_from_rob = 1'b0;
      checks++; if ({ena_to_mc, addr_to_mc} !== {1'b1, 32'h300}) begin failures++; $display("FAIL flush_held got ena=%0b addr=%h exp 1/300", ena_to_mc, addr_to_mc); end
      @(negedge clk);
      done_from_mc = 1'b1; data_from_mc = 32'hDEADBEEF;
      @(negedge clk);
      done_from_mc = 1'b0;
      checks++; if ({valid_to_cdb, ena_to_mc, busy_to_lsb} !== 3'b000) begin failures++; $display("FAIL flush_drop got v=%0b ena=%0b busy=%0b exp 0/0/0", valid_to_cdb, ena_to_mc, busy_to_lsb); end
      @(negedge clk);
      checks++; if (valid_to_cdb !== 1'b0) begin failures++; $display("FAIL flush_late_pulse got=%0b exp=0", valid_to_cdb); end
      do_issue(6'd3, 32'h304, 32'h0, 5'd6);
      done_from_mc = 1'b1; data_from_mc = 32'h11223344;
      @(negedge clk);
      done_from_mc = 1'b0;
      checks++; if ({valid_to_cdb, rob_id_to_cdb, result_to_cdb} !== {1'b1, 5'd6, 32'h11223344}) begin failures++; $display("FAIL flush_next_load got v=%0b rob=%0d res=%h exp 1/6/11223344", valid_to_cdb, rob_id_to_cdb, result_to_cdb); end
      $display("txn flush 2 cycles before done, then LW rob=6");
      do_issue(6'd3, 32'h308, 32'h0, 5'd7);
      done_from_mc = 1'b1; data_from_mc = 32'h99999999; commit_jump_flag_from_rob = 1'b1;
      @(negedge clk);
      done_from_mc = 1'b0; commit_jump_flag_from_rob = 1'b0;
      checks++; if ({valid_to_cdb, ena_to_mc} !== 2'b00) begin failures++; $display("FAIL flush_on_done got v=%0b ena=%0b exp 0/0", valid_to_cdb, ena_to_mc); end
      do_issue(6'd8, 32'h30C, 32'h77, 5'd9);
      commit_jump_flag_from_rob = 1'b1;
      @(negedge clk);
      commit_jump_flag_from_rob = 1'b0;
      checks++; if ({ena_to_mc, wr_to_mc, size_to_mc} !== {1'b1, 1'b1, 3'd4}) begin failures++; $display("FAIL flush_store_held got ena=%0b wr=%0b size=%0d exp 1/1/4", ena_to_mc, wr_to_mc, size_to_mc); end
      done_from_mc = 1'b1;
      @(negedge clk);
      done_from_mc = 1'b0;
      checks++; if ({valid_to_cdb, ena_to_mc, busy_to_lsb} !== 3'b000) begin failures++; $display("FAIL flush_store_done got v=%0b ena=%0b busy=%0b exp 0/0/0", valid_to_cdb, ena_to_mc, busy_to_lsb); end
      $display("txn flush on done cycle, flush during store");
   endtask

   task automatic test_async_reset;
      do_issue(6'd3, 32'h400, 32'h0, 5'd2);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      checks++; if ({ena_to_mc, wr_to_mc, size_to_mc, addr_to_mc, busy_to_lsb, valid_to_cdb} !== 38'd0) begin failures++; $display("FAIL async_rst got ena=%0b size=%0d addr=%h busy=%0b v=%0b exp 0", ena_to_mc, size_to_mc, addr_to_mc, busy_to_lsb, valid_to_cdb); end
      @(negedge clk);
      rst = 1'b0;
      done_from_mc = 1'b1; data_from_mc = 32'hABCDABCD;
      @(negedge clk);
      done_from_mc = 1'b0;
      checks++; if ({valid_to_cdb, ena_to_mc, busy_to_lsb} !== 3'b000) begin failures++; $display("FAIL late_done got v=%0b ena=%0b busy=%0b exp 0/0/0", valid_to_cdb, ena_to_mc, busy_to_lsb); end
      $display("txn async reset mid-request, late done ignored");
   endtask

   initial begin
      rst = 1'b1; ena_from_lsb = 1'b0; openum_from_lsb = '0; mem_addr_from_lsb = '0;
      store_value_from_lsb = '0; rob_id_from_lsb = '0; done_from_mc = 1'b0;
      data_from_mc = '0; commit_jump_flag_from_rob = 1'b0;
      @(negedge clk);
      test_reset;
      test_lw;
      test_extend;
      test_store;
      test_back_to_back;
      test_flush;
      test_async_reset;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
